token_out_buffer: RTL and testbench
===================================

Name: token_out_buffer

Overview:
- Registered elastic output stage on the forward-token (FTk_t) result path of an ALU lane, e.g. after the shift unit.
- Receives the combinational result token, buffers it in a small FIFO and presents it to the downstream consumer.
- Runs the backward-token (BTk_t) side toward the producer: nack on full, and registered relay of terminal/condition tokens returned by the consumer.
- Tracks acquire/release framing so the lane knows when a token stream has fully drained.

Parameters:
- DEPTH, 2, number of FTk_t entries; power of two, at least 2.
- WIDTH_DATA, from pkg_en, data width of FTk_t.d; informational, because the struct types carry the widths.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- I_FTk  in  FTk_t  forward token from the producer (ALU result).
- O_BTk  out  BTk_t  backward token to the producer.
- O_FTk  out  FTk_t  forward token to the consumer.
- I_BTk  in  BTk_t  backward token from the consumer.
- O_Busy  out  1  high while a framed stream is open or not yet drained.
- O_Count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, read/write pointers 0, Count=0. O_FTk is all-zero (.v=0). O_BTk is all-zero. FSM=IDLE, O_Busy=0.
- Enqueue: I_FTk.v=1 and Count<DEPTH. The whole struct (v, a, c, r, d, plus i under EXTEND) is written at wptr, and wptr wraps modulo DEPTH.
- Dequeue: O_FTk.v=1 and I_BTk.n=0. rptr advances with wrap.
- Output register:
  - O_FTk shows the head entry whenever Count>0 and has .v=0 when empty. All fields are registered.
  - Latency from an empty buffer: a token enqueued in cycle t appears on O_FTk in cycle t+1.
- Nack:
  - O_BTk.n = (Count==DEPTH). It is registered, with no combinational path from I_FTk or I_BTk.
  - The producer holds its token while n=1. The buffer ignores I_FTk.v while full, even if a dequeue happens in the same cycle.
- Simultaneous enqueue and dequeue when 0<Count<DEPTH: Count is unchanged and both pointers advance.
- Dequeue when empty cannot occur. Enqueue when full is ignored and never overwrites an entry.
- Backward relay:
  - O_BTk.t, O_BTk.v and O_BTk.c equal I_BTk.t, I_BTk.v and I_BTk.c delayed by exactly one cycle.
  - The relay is independent of FIFO state.
- Framing FSM, evaluated on dequeued tokens:
  - IDLE -> OPEN when a token with .a=1 is dequeued.
  - OPEN -> DRAIN when a token with .r=1 is dequeued.
  - DRAIN -> IDLE when Count==0 and no enqueue in the same cycle. If an enqueue happens that cycle, the FSM stays in DRAIN.
  - A single token with a=1 and r=1 goes IDLE -> DRAIN.
  - O_Busy = (FSM!=IDLE) or (Count!=0).
- Reset asserted mid-operation: all state clears immediately, in-flight tokens are dropped, and O_FTk.v falls without waiting for a clock edge.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release -> O_FTk.v=0, O_BTk.n=0, O_Count=0, O_Busy=0.
- Single token:
  - Stimulus: I_FTk={v=1, a=1, r=0, d=0x5A} for one cycle, I_BTk.n=0.
  - Response: next cycle O_FTk.v=1 and .d=0x5A. The cycle after, O_FTk.v=0, O_Count=0, O_Busy=1 (FSM in OPEN).
- Fill/backpressure:
  - Stimulus: I_BTk.n=1, present d=1, 2, 3 on consecutive cycles.
  - Response: after two enqueues O_BTk.n=1 and O_Count=2. d=3 is held by the producer, not lost.
  - Then release I_BTk.n=0 -> O_FTk.d sequence is 1, 2, 3 with no duplicates.
- Streaming with wrap: 10 back-to-back tokens d=0..9 with I_BTk.n=0 -> output d=0..9 in order with 1-cycle latency, O_Count never exceeds 1, pointers wrap cleanly.
- Framing drain:
  - Stimulus: tokens {a=1, d=7}, {d=8}, {r=1, d=9}.
  - Response: O_Busy=1 from the first dequeue. After d=9 dequeues with an empty buffer, O_Busy=0 within 1 cycle.
- Relay and async reset:
  - Stimulus: I_BTk={t=1, v=1, c=1} in cycle t.
  - Response: O_BTk.t/.v/.c equal 1 in cycle t+1 only.
  - Asserting reset mid-cycle with O_Count=2 clears O_FTk.v and O_Count immediately.

Source files
------------

// File: rtl/token_out_buffer.sv
// token_out_buffer
//   Registered elastic output stage on the forward-token result path of an
//   ALU lane. Result tokens are queued in a small FIFO and presented to the
//   consumer from a register. Toward the producer, the stage drives a
//   registered nack when the FIFO is full. It also relays the consumer's
//   terminal/valid/condition bits one cycle later. A small framing FSM
//   follows acquire (a) / release (r) on dequeued tokens, so the lane can tell
//   when a token stream has fully drained.
//
// Ports
//   clock    : single clock
//   reset    : asynchronous, active-low reset
//   I_FTk    : forward token from the producer (ALU result)
//   O_BTk    : backward token to the producer (n = full, t/v/c relayed)
//   O_FTk    : forward token to the consumer (registered FIFO head)
//   I_BTk    : backward token from the consumer (n = stall)
//   O_Busy   : framed stream open / draining, or FIFO not empty
//   O_Count  : current FIFO occupancy

package pkg_en;
   localparam int WIDTH_DATA = 8;

   typedef struct packed {
      logic                  v;
      logic                  a;
      logic                  c;
      logic                  r;
      logic [WIDTH_DATA-1:0] d;
   } FTk_t;

   typedef struct packed {
      logic n;
      logic t;
      logic v;
      logic c;
   } BTk_t;
endpackage

module token_out_buffer #(
   parameter int DEPTH      = 2,
   parameter int WIDTH_DATA = pkg_en::WIDTH_DATA
) (
   input  logic                       clock,
   input  logic                       reset,
   input  pkg_en::FTk_t               I_FTk,
   output pkg_en::BTk_t               O_BTk,
   output pkg_en::FTk_t               O_FTk,
   input  pkg_en::BTk_t               I_BTk,
   output logic                       O_Busy,
   output logic [$clog2(DEPTH):0]     O_Count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_COUNT  = CW'(1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] OPEN  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
      $error("token_out_buffer: DEPTH must be a power of two, at least 2");
   end
   if (WIDTH_DATA != pkg_en::WIDTH_DATA) begin : gBadWidth
      $error("token_out_buffer: WIDTH_DATA must match pkg_en::WIDTH_DATA");
   end

   pkg_en::FTk_t      mem [DEPTH];
   pkg_en::FTk_t      outTok;
   pkg_en::FTk_t      headNext;
   pkg_en::BTk_t      backTok;
   logic [PW-1:0]     rPtr;
   logic [PW-1:0]     wPtr;
   logic [PW-1:0]     rPtrNext;
   logic [CW-1:0]     count;
   logic [CW-1:0]     countNext;
   logic [1:0]        state;
   logic [1:0]        stateNext;
   logic              full;
   logic              enq;
   logic              deq;

   // Full blocks enqueue even when a dequeue frees a slot in the same cycle.
   // This keeps the accept decision consistent with the registered nack the
   // producer sees.
   assign full = (count == FULL_COUNT);
   assign enq  = I_FTk.v && !full;
   assign deq  = outTok.v && !I_BTk.n;

   always_comb begin
      countNext = count;
      if (enq && !deq) begin
         countNext = count + 1'b1;
      end else if (!enq && deq) begin
         countNext = count - 1'b1;
      end
   end

   assign rPtrNext = deq ? rPtr + 1'b1 : rPtr;

   // The output register is loaded with the head as it will be after this
   // edge. If the incoming token becomes the only entry, it bypasses storage.
   // That gives one cycle of latency from an empty buffer.
   always_comb begin
      headNext = '0;
      if (enq && countNext == ONE_COUNT) begin
         headNext = I_FTk;
      end else if (countNext != '0) begin
         headNext = mem[rPtrNext];
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (deq && outTok.a) begin
               stateNext = outTok.r ? DRAIN : OPEN;
            end
         end
         OPEN: begin
            if (deq && outTok.r) begin
               stateNext = DRAIN;
            end
         end
         DRAIN: begin
            if (count == '0 && !enq) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (enq) begin
         mem[wPtr] <= I_FTk;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rPtr    <= '0;
         wPtr    <= '0;
         count   <= '0;
         outTok  <= '0;
         backTok <= '0;
         state   <= IDLE;
      end else begin
         rPtr    <= rPtrNext;
         if (enq) begin
            wPtr <= wPtr + 1'b1;
         end
         count   <= countNext;
         outTok  <= headNext;
         backTok <= '{n: (countNext == FULL_COUNT), t: I_BTk.t, v: I_BTk.v, c: I_BTk.c};
         state   <= stateNext;
      end
   end

   assign O_FTk   = outTok;
   assign O_BTk   = backTok;
   assign O_Count = count;
   assign O_Busy  = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_token_out_buffer.sv
// tb_token_out_buffer
//   Drives token_out_buffer with directed scenarios and randomized
//   producer/consumer traffic. Outputs are compared against a queue-based
//   reference model of the buffer's visible behaviour.
module tb_token_out_buffer;
   import pkg_en::*;

   localparam int DEPTH = 2;

   logic               clock;
   logic               reset;
   FTk_t               ftkIn;
   BTk_t               btkIn;
   BTk_t               O_BTk;
   FTk_t               O_FTk;
   logic               O_Busy;
   logic [$clog2(DEPTH):0] O_Count;

   token_out_buffer #(.DEPTH(DEPTH), .WIDTH_DATA(WIDTH_DATA)) dut (
      .clock   (clock),
      .reset   (reset),
      .I_FTk   (ftkIn),
      .O_BTk   (O_BTk),
      .O_FTk   (O_FTk),
      .I_BTk   (btkIn),
      .O_Busy  (O_Busy),
      .O_Count (O_Count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   // Reference model: queue contents, framing flags, last relayed bits
   FTk_t      q[$];
   bit        frameOpen;
   bit        frameDraining;
   BTk_t      prevB;
   int        outLog[$];

   task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      q.delete();
      frameOpen     = 1'b0;
      frameDraining = 1'b0;
      prevB         = '0;
   endtask

   // One clock edge of the reference, using the inputs present before it
   task automatic modelStep(input FTk_t f, input BTk_t b, output bit accepted);
      bit   deq;
      bit   enq;
      FTk_t head;
      deq = (q.size() > 0) && !b.n;
      enq = f.v && (q.size() < DEPTH);
      if (deq) begin
         head = q[0];
         if (!frameOpen && !frameDraining && head.a) begin
            if (head.r) frameDraining = 1'b1;
            else        frameOpen     = 1'b1;
         end else if (frameOpen && head.r) begin
            frameOpen     = 1'b0;
            frameDraining = 1'b1;
         end
      end else if (frameDraining && q.size() == 0 && !enq) begin
         frameDraining = 1'b0;
      end
      if (deq) void'(q.pop_front());
      if (enq) q.push_back(f);
      prevB    = b;
      accepted = enq;
   endtask

   task automatic checkAll();
      FTk_t expF;
      BTk_t expB;
      expF = (q.size() > 0) ? q[0] : '0;
      expB = '{n: (q.size() == DEPTH), t: prevB.t, v: prevB.v, c: prevB.c};
      checkEq("oFtk",  O_FTk,   expF);
      checkEq("oBtk",  O_BTk,   expB);
      checkEq("count", O_Count, q.size());
      checkEq("busy",  O_Busy,  frameOpen || frameDraining || q.size() != 0);
   endtask

   // Called at a negedge: drive, log the DUT's handshake, step, check after edge
   task automatic cycle(input FTk_t f, input BTk_t b, output bit acc);
      ftkIn = f;
      btkIn = b;
      if (O_FTk.v && !b.n) outLog.push_back(int'(O_FTk.d));
      modelStep(f, b, acc);
      @(posedge clock);
      #1;
      checkAll();
      @(negedge clock);
   endtask

   task automatic doReset();
      ftkIn = '0;
      btkIn = '0;
      reset = 1'b0;
      modelReset();
      repeat (3) @(negedge clock);
      reset = 1'b1;
   endtask

   function automatic FTk_t mkTok(bit a, bit r, int d);
      FTk_t t;
      t   = '0;
      t.v = 1'b1;
      t.a = a;
      t.r = r;
      t.d = d[WIDTH_DATA-1:0];
      return t;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit   acc;
      FTk_t f;
      BTk_t b;
      FTk_t pend;
      bit   pending;
      int   idx;
      int   fillData[3];
      fillData = '{1, 2, 3};

      // Reset then idle
      @(negedge clock);
      doReset();
      #1;
      checkEq("rstV",    O_FTk.v, 1'b0);
      checkEq("rstN",    O_BTk.n, 1'b0);
      checkEq("rstCnt",  O_Count, 0);
      checkEq("rstBusy", O_Busy,  1'b0);
      @(negedge clock);

      // Single token
      b = '0;
      cycle(mkTok(1, 0, 8'h5A), b, acc);
      checkEq("singleV", O_FTk.v, 1'b1);
      checkEq("singleD", O_FTk.d, 8'h5A);
      cycle('0, b, acc);
      checkEq("singleV2",   O_FTk.v, 1'b0);
      checkEq("singleCnt",  O_Count, 0);
      checkEq("singleBusy", O_Busy,  1'b1);

      // Fill / backpressure with a holding producer
      doReset();
      outLog.delete();
      idx = 0;
      for (int c = 0; c < 12; c++) begin
         f = (idx < 3) ? mkTok(0, 0, fillData[idx]) : FTk_t'('0);
         b = '0;
         b.n = (c < 4);
         cycle(f, b, acc);
         if (acc) idx++;
         if (c == 1) begin
            checkEq("fillN",   O_BTk.n, 1'b1);
            checkEq("fillCnt", O_Count, 2);
         end
      end
      checkEq("fillLen", outLog.size(), 3);
      for (int i = 0; i < 3 && i < outLog.size(); i++) checkEq("fillSeq", outLog[i], fillData[i]);

      // Streaming with pointer wrap
      doReset();
      outLog.delete();
      for (int c = 0; c < 13; c++) begin
         f = (c < 10) ? mkTok(0, 0, c) : FTk_t'('0);
         cycle(f, '0, acc);
         checkEq("streamCntLE1", O_Count <= 1, 1'b1);
      end
      checkEq("streamLen", outLog.size(), 10);
      for (int i = 0; i < 10 && i < outLog.size(); i++) checkEq("streamSeq", outLog[i], i);

      // Framing drain
      doReset();
      cycle(mkTok(1, 0, 7), '0, acc);
      cycle(mkTok(0, 0, 8), '0, acc);
      checkEq("frameBusyOpen", O_Busy, 1'b1);
      cycle(mkTok(0, 1, 9), '0, acc);
      cycle('0, '0, acc);
      checkEq("frameBusyDrain", O_Busy, 1'b1);
      cycle('0, '0, acc);
      checkEq("frameIdle", O_Busy, 1'b0);

      // Backward relay, one cycle only
      doReset();
      b = '{n: 1'b0, t: 1'b1, v: 1'b1, c: 1'b1};
      cycle('0, b, acc);
      checkEq("relayOn", O_BTk[2:0], 3'b111);
      cycle('0, '0, acc);
      checkEq("relayOff", O_BTk[2:0], 3'b000);

      // Asynchronous reset while two tokens are held
      doReset();
      b = '0;
      b.n = 1'b1;
      cycle(mkTok(0, 0, 33), b, acc);
      cycle(mkTok(0, 0, 44), b, acc);
      checkEq("preRstCnt", O_Count, 2);
      #2;
      reset = 1'b0;
      #1;
      checkEq("asyncV",    O_FTk.v, 1'b0);
      checkEq("asyncCnt",  O_Count, 0);
      checkEq("asyncBusy", O_Busy,  1'b0);
      checkEq("asyncBtk",  O_BTk,   4'b0000);
      modelReset();
      ftkIn = '0;
      btkIn = '0;
      @(negedge clock);
      reset = 1'b1;

      // Randomized producer/consumer traffic
      pending = 1'b0;
      pend    = '0;
      for (int c = 0; c < 600; c++) begin
         if (!pending && ($urandom % 3 != 0)) begin
            pend   = mkTok(($urandom % 8) == 0, ($urandom % 8) == 0, int'($urandom % 256));
            pend.c = 1'($urandom);
            pending = 1'b1;
         end
         f = pending ? pend : FTk_t'('0);
         b.n = ($urandom % 3) == 0;
         b.t = 1'($urandom);
         b.v = 1'($urandom);
         b.c = 1'($urandom);
         cycle(f, b, acc);
         if (acc) pending = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
